// File: rtl/crc_stream_pkg.sv
// Shared types and constants for the streaming CRC engine.
package crc_stream_pkg;

    localparam int unsigned CRC_MAX_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Mask with the low w bits set; used for the all-ones INIT default.
    function automatic logic [CRC_MAX_W-1:0] crc_ones(input int unsigned w);
        logic [CRC_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < CRC_MAX_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/crc_stream_engine_step.sv
// One word of MSB-first serial CRC, unrolled into a single combinational stage.
module crc_step_comb #(
    parameter int unsigned           CRC_W  = 5,
    parameter logic [CRC_W-1:0]      POLY   = 5'h05,
    parameter int unsigned           DATA_W = 64
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_nxt
);

    logic [CRC_W-1:0] c;
    logic             fb;

    // Shift every data bit through the LFSR, highest bit first.
    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb = c[CRC_W-1] ^ data[DATA_W-1-i];
            c  = (c << 1) ^ (fb ? POLY : '0);
        end
        crc_nxt = c;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: multi-word frames in, one result handshake out.
module crc_stream_engine
    import crc_stream_pkg::*;
#(
    parameter int unsigned      CRC_W   = 5,
    parameter logic [CRC_W-1:0] POLY    = 5'h05,
    parameter logic [CRC_W-1:0] INIT    = CRC_W'(crc_ones(CRC_W)),
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter int unsigned      DATA_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] data_in,
    input  logic              chk_en,
    input  logic [CRC_W-1:0]  crc_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_err,
    output logic              abort
);

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] res_q, res_d;
    logic             chk_q, chk_d;
    logic             err_q, err_d;
    logic             abort_q, abort_d;
    logic             rdy_q;

    logic             accept;
    logic             start;
    logic             cont;
    logic             chk_eff;
    logic [CRC_W-1:0] crc_base;
    logic [CRC_W-1:0] crc_nxt;
    logic [CRC_W-1:0] crc_fin;

    // A sop always restarts from INIT, even inside an open frame.
    assign crc_base = in_sop ? INIT : crc_q;

    crc_step_comb #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .DATA_W (DATA_W)
    ) u_step (
        .crc_in  (crc_base),
        .data    (data_in),
        .crc_nxt (crc_nxt)
    );

    assign in_ready  = rdy_q && ((state_q != StDone) || out_ready);
    assign accept    = in_valid && in_ready;
    assign start     = accept && in_sop;
    assign cont      = accept && !in_sop && (state_q == StBusy);
    assign chk_eff   = start ? chk_en : chk_q;
    assign crc_fin   = crc_nxt ^ XOR_OUT;
    assign out_valid = (state_q == StDone);
    assign crc_out   = res_q;
    assign crc_err   = err_q;
    assign abort     = abort_q;

    // Next-state: frame accumulation, result capture at eop, abort on re-sop.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        chk_d   = chk_q;
        res_d   = res_q;
        err_d   = err_q;
        abort_d = 1'b0;
        if (start || cont) begin
            crc_d   = crc_nxt;
            abort_d = start && (state_q == StBusy);
            if (start) chk_d = chk_en;
            if (in_eop) begin
                state_d = StDone;
                res_d   = crc_fin;
                err_d   = chk_eff && (crc_fin != crc_exp);
            end else begin
                state_d = StBusy;
            end
        end else if ((state_q == StDone) && out_ready) begin
            state_d = StIdle;
        end
    end

    // State registers; rdy_q holds in_ready low for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            crc_q   <= INIT;
            chk_q   <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            chk_q   <= chk_d;
            res_q   <= res_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised streaming CRC generator/checker; successor to the fixed 5-bit, single-word crc5 block.
- Accepts a frame of one or more DATA_W-bit words over a valid/ready handshake, accumulating CRC across words.
- Presents the result with an output handshake. Optional check mode compares the result against an expected value.
- Sits between the packet datapath and the link framer; one instance per lane.

Parameters:
- CRC_W, 5, CRC width in bits (1..32).
- POLY, 5'h05, generator polynomial, implicit x^CRC_W term omitted, MSB-first (non-reflected).
- INIT, all ones, CRC register value loaded at start of frame.
- XOR_OUT, 0, value XORed into the result before output.
- DATA_W, 64, input word width; processed MSB (bit DATA_W-1) first.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; release is synchronous to clk externally.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- in_sop  in  1  first word of frame; qualified by in_valid.
- in_eop  in  1  last word of frame; may coincide with in_sop.
- data_in  in  DATA_W  frame data word.
- chk_en  in  1  sampled with sop beat; 1 = check mode.
- crc_exp  in  CRC_W  expected CRC, sampled with eop beat when check mode is active.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- crc_out  out  CRC_W  final CRC (after XOR_OUT).
- crc_err  out  1  check mode only: crc_out != crc_exp; 0 in generate mode.
- abort  out  1  one-cycle pulse: a sop arrived while a frame was open.

Behaviour:
- Reset (rst=0, async): state IDLE, crc register = INIT, in_ready=0 for the reset cycle then 1, out_valid=0, crc_out=0, crc_err=0, abort=0.
- Beat accepted when in_valid && in_ready.
- Next CRC per word: serial LFSR over DATA_W bits, MSB first, fb = crc[CRC_W-1]^d; crc = (crc<<1) ^ (fb ? POLY : 0), unrolled combinationally to one word per cycle.
- Throughput: one word per cycle.
- States:
  - IDLE: beats without sop are accepted and discarded.
    - sop beat: crc = step(INIT, data); latch chk_en; go BUSY, or straight to DONE if eop is also set.
  - BUSY: each beat updates crc = step(crc, data).
    - eop beat: go DONE.
    - sop beat: abort pulse next cycle; restart with crc = step(INIT, data), chk_en re-latched.
  - DONE: out_valid=1, crc_out = crc ^ XOR_OUT, crc_err registered at the eop beat; in_ready = out_ready.
    - out_valid && out_ready: go IDLE. A simultaneous input sop beat is accepted and opens a new frame (BUSY, or DONE if it also carries eop) with no bubble.
- Latency: out_valid rises on the cycle after the eop beat is accepted.
- Output stability: crc_out and crc_err are stable while out_valid=1 and out_ready=0.
- Reset mid-frame: partial frame discarded, no output produced.

Decomposition:
- Package crc_stream_pkg: state enum (IDLE, BUSY, DONE); localparam helpers for the all-ones INIT default.
- Sub-module crc_step_comb: purely combinational next-CRC of (crc_in, data) parametrised by CRC_W/POLY/DATA_W. Reused by future parallel-lane variants.

Test Plan:
- CRC_W=8, POLY=8'h07, INIT=0, DATA_W=8; feed ASCII "123456789", sop on '1', eop on '9' -> crc_out=8'hF4, out_valid one cycle after eop, crc_err=0.
- CRC_W=16, POLY=16'h1021, INIT=0, DATA_W=8; same string with chk_en=1 and crc_exp=16'h31C3 -> crc_out=16'h31C3, crc_err=0. Repeat with crc_exp=16'h31C2 -> crc_err=1.
- CRC_W=32, POLY=32'h04C11DB7, INIT=32'hFFFFFFFF, DATA_W=8; "123456789" -> crc_out=32'h0376E6E7. Hold out_ready=0 for 5 cycles -> in_ready=0, out_valid and crc_out stable throughout.
- Defaults (CRC_W=5, DATA_W=64, INIT=5'h1F); single beat, sop=eop=1, data 64'h0 -> crc_out equals 64 serial LFSR steps from 5'h1F as computed by the bench reference model. Back-to-back single-beat frames with out_ready=1 -> one result per cycle.
- Open a frame, send 2 beats, then a new sop -> abort pulse for one cycle; final crc_out matches the second frame only.
- Assert rst low mid-frame for 1 cycle -> out_valid=0, crc_out=0. The next full frame produces the correct CRC.
